// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests, fetch queue towards decode.
// Define IFETCH_MISALIGN_TRAP_EN to turn misaligned redirects into a trap entry instead of fetching.
module ifetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            id_ready_i,
    output logic            id_valid_o,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pcplus4_o,
    output logic            id_misalign_o
);
    localparam int unsigned PW     = $clog2(FQ_DEPTH);
    localparam int unsigned CW     = PW + 1;
    localparam logic [CW:0] DepthC = FQ_DEPTH[CW:0];
    localparam logic [31:0] Nop    = 32'h0000_0013;

    logic [XLEN-1:0] pc_q, pc_d, redir_tgt;
    logic [CW-1:0]   out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [PW-1:0]   tag_wr_q, tag_rd_q, fq_wr_q, fq_rd_q;
    logic [XLEN-1:0] tag_q      [FQ_DEPTH];
    logic [31:0]     fq_instr_q [FQ_DEPTH];
    logic [XLEN-1:0] fq_pc_q    [FQ_DEPTH];
    logic            halt_q, redir_mis, req_fire, rsp_push, id_pop;

    // Outstanding requests plus queued entries never exceed the queue depth, so pushes always fit.
    assign imem_req_valid_o = !reset && !redirect_i && !halt_q &&
                              (({1'b0, out_q} + {1'b0, cnt_q}) < DepthC);
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_push         = imem_rsp_valid_i && !redirect_i && (drop_q == '0);
    assign id_pop           = id_valid_o && id_ready_i && !redirect_i;

    assign id_valid_o   = (cnt_q != '0);
    assign id_instr_o   = id_valid_o ? fq_instr_q[fq_rd_q] : Nop;
    assign id_pc_o      = fq_pc_q[fq_rd_q];
    assign id_pcplus4_o = id_pc_o + XLEN'(4);

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic fq_mis_q [FQ_DEPTH];

    assign redir_mis     = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign redir_tgt     = redirect_pc_i;
    assign id_misalign_o = id_valid_o && fq_mis_q[fq_rd_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else if (redirect_i) begin
            halt_q <= redir_mis;
        end
        if (redirect_i) begin
            fq_mis_q[0] <= redir_mis;
        end else if (rsp_push) begin
            fq_mis_q[fq_wr_q] <= 1'b0;
        end
    end
`else
    logic unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];
    assign redir_mis      = 1'b0;
    assign redir_tgt      = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign halt_q         = 1'b0;
    assign id_misalign_o  = 1'b0;
`endif

    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
        drop_d = drop_q;
        cnt_d  = cnt_q + CW'(rsp_push) - CW'(id_pop);
        if (imem_rsp_valid_i && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end
        // Every request still in flight after this cycle belongs to the abandoned path.
        if (redirect_i) begin
            pc_d   = redir_tgt;
            drop_d = out_q - CW'(imem_rsp_valid_i);
            cnt_d  = CW'(redir_mis);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            fq_wr_q  <= '0;
            fq_rd_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            if (req_fire) begin
                tag_wr_q <= tag_wr_q + PW'(1);
            end
            if (imem_rsp_valid_i) begin
                tag_rd_q <= tag_rd_q + PW'(1);
            end
            if (redirect_i) begin
                fq_rd_q <= '0;
                fq_wr_q <= PW'(redir_mis);
            end else begin
                if (rsp_push) begin
                    fq_wr_q <= fq_wr_q + PW'(1);
                end
                if (id_pop) begin
                    fq_rd_q <= fq_rd_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
        end
        if (redirect_i) begin
            if (redir_mis) begin
                fq_instr_q[0] <= Nop;
                fq_pc_q[0]    <= redirect_pc_i;
            end
        end else if (rsp_push) begin
            fq_instr_q[fq_wr_q] <= imem_rsp_data_i;
            fq_pc_q[fq_wr_q]    <= tag_q[tag_rd_q];
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: in-order variable-latency imem model, expected-stream scoreboard.
module tb_ifetch_unit;
    localparam int unsigned FQ_DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid, id_misalign;
    logic [31:0] id_instr, id_pc, id_pcplus4;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int unsigned lat = 1;
    int unsigned rdy_pct = 100;
    int unsigned idr_pct = 100;
    int unsigned fire_cnt = 0;
    exp_t        exp_q[$];
    mem_t        mem_q[$];
    logic [31:0] stream_pc, req_exp;
    bit          streaming, req_halt;

    ifetch_unit #(
        .XLEN    (32),
        .RESET_PC(RESET_PC),
        .FQ_DEPTH(FQ_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid_o(req_valid),
        .imem_req_ready_i(req_ready),
        .imem_req_addr_o (req_addr),
        .imem_rsp_valid_i(rsp_valid),
        .imem_rsp_data_i (rsp_data),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .id_ready_i      (id_ready),
        .id_valid_o      (id_valid),
        .id_instr_o      (id_instr),
        .id_pc_o         (id_pc),
        .id_pcplus4_o    (id_pcplus4),
        .id_misalign_o   (id_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Program order after a reset/redirect is simply target, target+4, ... (or one trap entry).
    task automatic model_restart(input logic [31:0] t);
        exp_q.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) begin
            exp_q.push_back('{pc: t, instr: NOP, mis: 1'b1});
            streaming = 1'b0;
            req_halt  = 1'b1;
            return;
        end
`endif
        streaming = 1'b1;
        req_halt  = 1'b0;
        stream_pc = {t[31:2], 2'b00};
        req_exp   = stream_pc;
    endtask

    task automatic refill();
        while (streaming && exp_q.size() < 8) begin
            exp_q.push_back('{pc: stream_pc, instr: instr_of(stream_pc), mis: 1'b0});
            stream_pc += 32'd4;
        end
    endtask

    task automatic cycle(input bit rst, input bit rdr, input logic [31:0] tgt);
        mem_t m;
        @(negedge clk);
        reset       = rst;
        redirect    = rdr && !rst;
        redirect_pc = tgt;
        rsp_valid   = 1'b0;
        rsp_data    = $urandom;
        if (rst) begin
            mem_q.delete();
            last_due = cyc;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        req_ready = ($urandom_range(99) < rdy_pct);
        id_ready  = ($urandom_range(99) < idr_pct);
        if (rst) model_restart(RESET_PC);
        else if (rdr) model_restart(tgt);
        refill();
        #1;
        if (rst || rdr) chk(!req_valid, "req_quiet", 32'(req_valid), 32'd0);
        if (req_valid && req_ready) begin
            fire_cnt++;
            chk(!req_halt, "req_after_trap", req_addr, 32'd0);
            chk(req_addr == req_exp, "req_addr", req_addr, req_exp);
            req_exp += 32'd4;
            m.addr   = req_addr;
            m.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = m.due;
            mem_q.push_back(m);
            chk(mem_q.size() <= FQ_DEPTH, "outstanding", 32'(mem_q.size()), FQ_DEPTH);
        end
        @(posedge clk);
        cyc++;
    endtask

    // Monitor: pops the scoreboard on every decode handshake and checks hold/reset rules.
    bit          prev_hold = 1'b0, rst_seen = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    int          idle = 0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_seen) begin
            chk(!id_valid, "rst_id_valid", 32'(id_valid), 32'd0);
            chk(!id_misalign, "rst_misalign", 32'(id_misalign), 32'd0);
        end
        if (!id_valid) chk(id_instr == NOP, "empty_nop", id_instr, NOP);
        if (reset || redirect) idle = 0;
        if (!reset) begin
            if (prev_hold) begin
                chk(id_valid, "hold_valid", 32'(id_valid), 32'd1);
                chk(id_pc == prev_pc, "hold_pc", id_pc, prev_pc);
                chk(id_instr == prev_instr, "hold_instr", id_instr, prev_instr);
            end
            if (id_valid && id_ready && !redirect) begin
                idle = 0;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_instr", id_pc, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(id_pc == e.pc, "id_pc", id_pc, e.pc);
                    chk(id_instr == e.instr, "id_instr", id_instr, e.instr);
                    chk(id_misalign == e.mis, "id_misalign", 32'(id_misalign), 32'(e.mis));
                    chk(id_pcplus4 == e.pc + 32'd4, "id_pcplus4", id_pcplus4, e.pc + 32'd4);
                end
            end else if (exp_q.size() > 0 && id_ready && !redirect) begin
                idle++;
                if (idle > 100) begin
                    chk(1'b0, "liveness", id_pc, exp_q[0].pc);
                    idle = 0;
                end
            end
        end
        prev_hold  = !reset && !redirect && id_valid && !id_ready;
        prev_pc    = id_pc;
        prev_instr = id_instr;
        rst_seen   = reset;
    end

    initial begin
        int unsigned f0, r;
        logic [31:0] t;
        bit          found;

        // Reset, then first-fetch latency with a 1-cycle memory.
        lat = 1; rdy_pct = 100; idr_pct = 100;
        repeat (3) cycle(1'b1, 1'b0, '0);
        f0 = fire_cnt;
        cycle(1'b0, 1'b0, '0);
        #2;
        chk(fire_cnt - f0 == 1, "first_fire", fire_cnt - f0, 32'd1);
        chk(!id_valid, "lat_early", 32'(id_valid), 32'd0);
        cycle(1'b0, 1'b0, '0);
        #2;
        chk(id_valid, "lat_first_valid", 32'(id_valid), 32'd1);
        chk(id_pc == RESET_PC, "lat_first_pc", id_pc, RESET_PC);
        repeat (20) cycle(1'b0, 1'b0, '0);

        // Decode stall straight out of reset: credit limits fetch to two requests.
        repeat (2) cycle(1'b1, 1'b0, '0);
        idr_pct = 0;
        f0 = fire_cnt;
        repeat (6) cycle(1'b0, 1'b0, '0);
        #2;
        chk(fire_cnt - f0 == 2, "stall_fires", fire_cnt - f0, 32'd2);
        chk(!req_valid, "stall_req_low", 32'(req_valid), 32'd0);
        chk(id_valid && id_pc == RESET_PC, "stall_head_pc", id_pc, RESET_PC);
        idr_pct = 100;
        repeat (20) cycle(1'b0, 1'b0, '0);

        // Redirect with two requests in flight on a 3-cycle memory.
        repeat (2) cycle(1'b1, 1'b0, '0);
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 1'b0, '0);
            #2;
            found = (mem_q.size() == 2);
        end
        chk(found, "setup_two_outstanding", 32'(mem_q.size()), 32'd2);
        cycle(1'b0, 1'b1, 32'h0000_0100);
        #2;
        chk(!id_valid, "flush_empty_a", 32'(id_valid), 32'd0);
        repeat (25) cycle(1'b0, 1'b0, '0);

        // Redirect coinciding with a response and a decode pop.
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 1'b0, '0);
            #2;
            found = id_valid && mem_q.size() > 0 && mem_q[0].due <= cyc;
        end
        chk(found, "setup_rsp_pop", 32'(found), 32'd1);
        cycle(1'b0, 1'b1, 32'h0000_0200);
        #2;
        chk(!id_valid, "flush_empty_b", 32'(id_valid), 32'd0);
        repeat (15) cycle(1'b0, 1'b0, '0);

        // Misaligned target, then a target at the top of the address space.
        cycle(1'b0, 1'b1, 32'h0000_0102);
        repeat (15) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (15) cycle(1'b0, 1'b0, '0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                lat     = $urandom_range(1, 4);
                rdy_pct = $urandom_range(30, 100);
                idr_pct = $urandom_range(20, 100);
            end
            r = $urandom_range(999);
            if (r < 3) begin
                repeat (2) cycle(1'b1, 1'b0, '0);
            end else if (r < 40) begin
                t = $urandom;
                r = $urandom_range(9);
                if (r == 0) t[0] = 1'b1;
                else if (r == 1) t = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
                else t[1:0] = 2'b00;
                cycle(1'b0, 1'b1, t);
            end else begin
                cycle(1'b0, 1'b0, '0);
            end
        end
        rdy_pct = 100;
        idr_pct = 100;
        repeat (30) cycle(1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
